// File: rtl/prbs15_pkg.sv
// Shared constants and state encoding for the PRBS-15 scrambler/descrambler pair.
package prbs15_pkg;

  localparam logic [14:0] PRBS15_SEED = 15'h00A9;
  localparam logic [7:0]  SYNC_BYTE   = 8'h47;
  localparam logic [7:0]  SYNC_INV    = 8'hB8;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_e;

endpackage

// File: rtl/prbs15_step8.sv
// Combinational PRBS-15 (1 + x^14 + x^15) advance by eight steps; keystream MSB is the first bit on the line.
module prbs15_step8
  import prbs15_pkg::*;
(
  input  logic [14:0] s_i,
  output logic [7:0]  ks_o,
  output logic [14:0] s_o
);

  logic fb;

  always_comb begin
    s_o  = s_i;
    ks_o = '0;
    fb   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb      = s_o[14] ^ s_o[13];
      ks_o[i] = fb;
      s_o     = {s_o[13:0], fb};
    end
  end

endmodule

// File: rtl/prbs15_sync_descrambler.sv
// PRBS-15 packet descrambler with sync hunting and lock tracking.
// Define DESCR_SYNC_ERR_CNT_EN to build the saturating sync error counter and its clr_err clear.
module prbs15_sync_descrambler
  import prbs15_pkg::*;
#(
  parameter int PKT_LEN  = 188,
  parameter int LOCK_CNT = 2,
  parameter int MISS_CNT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        locked,
  input  logic        clr_err,
  output logic [15:0] sync_err_cnt
);

  localparam int POS_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int MISS_W = (MISS_CNT > 1) ? $clog2(MISS_CNT + 1) : 1;

  localparam logic [POS_W-1:0]  PKT_LAST = POS_W'(PKT_LEN - 1);
  localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_TGT = MISS_W'(MISS_CNT);

  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d, pos_inc;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [14:0]        lfsr_q, lfsr_d, lfsr_step;
  logic [7:0]         ks;
  logic               out_valid_q, out_valid_d;
  logic               out_sof_q, out_sof_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               sync_ok;
  logic               err_inc;

  prbs15_step8 u_step8 (
    .s_i  (lfsr_q),
    .ks_o (ks),
    .s_o  (lfsr_step)
  );

  assign sync_ok = (in_data == SYNC_BYTE) || (in_data == SYNC_INV);
  assign pos_inc = (pos_q == PKT_LAST) ? '0 : pos_q + POS_W'(1);

  // A bad sync still consumes a keystream byte so payload stays aligned with the scrambler.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    good_d      = good_q;
    miss_d      = miss_q;
    lfsr_d      = lfsr_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_data_d  = out_data_q;
    err_inc     = 1'b0;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_data == SYNC_INV) begin
            lfsr_d  = PRBS15_SEED;
            pos_d   = POS_W'(1);
            good_d  = GOOD_W'(1);
            miss_d  = '0;
            state_d = (LOCK_CNT <= 1) ? LOCKED : CHECK;
          end
        end
        CHECK, LOCKED: begin
          out_valid_d = 1'b1;
          pos_d       = pos_inc;
          if (pos_q == '0) begin
            out_sof_d  = 1'b1;
            out_data_d = SYNC_BYTE;
            lfsr_d     = (in_data == SYNC_INV) ? PRBS15_SEED : lfsr_step;
            if (state_q == CHECK) begin
              if (sync_ok) begin
                good_d = good_q + GOOD_W'(1);
                if (good_d >= LOCK_TGT) begin
                  state_d = LOCKED;
                  miss_d  = '0;
                end
              end else begin
                state_d = HUNT;
                pos_d   = '0;
                good_d  = '0;
              end
            end else if (sync_ok) begin
              miss_d = '0;
            end else begin
              err_inc = 1'b1;
              miss_d  = miss_q + MISS_W'(1);
              if (miss_d >= MISS_TGT) begin
                state_d = HUNT;
                pos_d   = '0;
                miss_d  = '0;
                good_d  = '0;
              end
            end
          end else begin
            out_data_d = in_data ^ ks;
            lfsr_d     = lfsr_step;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      pos_q       <= '0;
      good_q      <= '0;
      miss_q      <= '0;
      lfsr_q      <= PRBS15_SEED;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_data  = out_data_q;
  assign locked    = (state_q == LOCKED);

`ifdef DESCR_SYNC_ERR_CNT_EN
  logic [15:0] err_q, err_d;

  // Clear has priority over a same-cycle increment.
  always_comb begin
    err_d = err_q;
    if (clr_err) begin
      err_d = '0;
    end else if (err_inc && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign sync_err_cnt = err_q;
`else
  logic unused_err_sigs;
  assign unused_err_sigs = clr_err ^ err_inc;
  assign sync_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_prbs15_sync_descrambler.sv
// Self-checking bench for prbs15_sync_descrambler; honours DESCR_SYNC_ERR_CNT_EN for the error counter expectations.
module tb_prbs15_sync_descrambler;

  localparam int PKT_LEN  = 188;
  localparam int LOCK_CNT = 2;
  localparam int MISS_CNT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        locked;
  logic        clr_err;
  logic [15:0] sync_err_cnt;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference keystream bytes indexed by bytes elapsed since the last inverted sync.
  logic [7:0] ksTab [0:4095];
  logic [7:0] plainMem [0:5][0:PKT_LEN-1];

  bit mHunt;
  bit mLocked;
  int mPos;
  int mGood;
  int mMiss;
  int mErr;
  int txIdx;

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         eV;
    logic [7:0] eD;
    bit         eS;
    bit         eL;
  } vec_t;

  vec_t vecs [6];

  prbs15_sync_descrambler #(
    .PKT_LEN  (PKT_LEN),
    .LOCK_CNT (LOCK_CNT),
    .MISS_CNT (MISS_CNT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_sof      (out_sof),
    .locked       (locked),
    .clr_err      (clr_err),
    .sync_err_cnt (sync_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #10ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void buildKeystream();
    logic [14:0] s;
    logic [7:0]  b;
    logic        f;
    s = 15'h00A9;
    for (int k = 0; k < 4096; k++) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
        f = s[14] ^ s[13];
        b = {b[6:0], f};
        s = {s[13:0], f};
      end
      ksTab[k] = b;
    end
  endfunction

  function automatic void resetModel();
    mHunt   = 1'b1;
    mLocked = 1'b0;
    mPos    = 0;
    mGood   = 0;
    mMiss   = 0;
    mErr    = 0;
    txIdx   = 0;
  endfunction

  function automatic logic [15:0] expErr();
`ifdef DESCR_SYNC_ERR_CNT_EN
    return mErr[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  // Behavioural sync/lock model of one accepted byte.
  function automatic void modelByte(input logic [7:0] d, output bit eV, output bit eS);
    bit good;
    eV = 1'b0;
    eS = 1'b0;
    if (mHunt) begin
      if (d == 8'hB8) begin
        mHunt   = 1'b0;
        mPos    = 1;
        mGood   = 1;
        mMiss   = 0;
        mLocked = (mGood >= LOCK_CNT);
      end
      return;
    end
    eV = 1'b1;
    eS = (mPos == 0);
    if (mPos == 0) begin
      good = (d == 8'h47) || (d == 8'hB8);
      if (!mLocked) begin
        if (good) begin
          mGood++;
          if (mGood >= LOCK_CNT) begin
            mLocked = 1'b1;
            mMiss   = 0;
          end
        end else begin
          mHunt = 1'b1;
        end
      end else if (good) begin
        mMiss = 0;
      end else begin
        if (mErr < 65535) mErr++;
        mMiss++;
        if (mMiss >= MISS_CNT) begin
          mLocked = 1'b0;
          mHunt   = 1'b1;
          mMiss   = 0;
        end
      end
    end
    mPos = (mPos + 1) % PKT_LEN;
  endfunction

  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit clr);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clr_err  = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input bit eV, input logic [7:0] eD,
                             input bit eS, input bit eL, input logic [15:0] eE);
    bit ok;
    testsRun++;
    ok = (out_valid === eV) && (out_sof === eS) && (locked === eL) &&
         (sync_err_cnt === eE) && (!eV || (out_data === eD));
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL %s: got v=%0b d=%h sof=%0b lock=%0b err=%0d, expected v=%0b d=%h sof=%0b lock=%0b err=%0d",
               name, out_valid, out_data, out_sof, locked, sync_err_cnt, eV, eD, eS, eL, eE);
    end
  endtask

  task automatic checkValue(input string name, input logic [15:0] got, input logic [15:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic resetDut();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clr_err  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
  endtask

  // Applies one byte; the expected payload value is the scrambler's plaintext.
  task automatic sendByte(input string name, input bit v, input logic [7:0] line,
                          input logic [7:0] plain, input bit clr);
    bit eV;
    bit eS;
    applyStimulus(v, line, clr);
    if (v) begin
      modelByte(line, eV, eS);
    end else begin
      eV = 1'b0;
      eS = 1'b0;
    end
    if (clr) mErr = 0;
    checkOutput(name, eV, eS ? 8'h47 : plain, eS, mLocked, expErr());
  endtask

  task automatic sendSync(input string name, input logic [7:0] line, input bit clr);
    if (line == 8'hB8) txIdx = 0;
    else               txIdx++;
    sendByte(name, 1'b1, line, 8'h00, clr);
  endtask

  task automatic sendPayload(input string name, input int pkt, input int fromPos,
                             input int toPos, input bit gaps);
    logic [7:0] plain;
    logic [7:0] line;
    for (int p = fromPos; p <= toPos; p++) begin
      plain = plainMem[pkt][p];
      line  = plain ^ ksTab[txIdx];
      txIdx++;
      if (mHunt && (line == 8'hB8)) line = line ^ 8'h01;
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          sendByte($sformatf("%s gap", name), 1'b0, 8'($urandom), 8'h00, 1'b0);
        end
      end
      sendByte($sformatf("%s pos%0d", name, p), 1'b1, line, plain, 1'b0);
    end
  endtask

  initial begin
    bit eV;
    bit eS;
    logic [7:0] junk;

    buildKeystream();
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < PKT_LEN; p++) begin
        plainMem[k][p] = 8'($urandom);
      end
    end

    // Acquisition from reset with an all-zero scrambled payload.
    resetDut();
    checkOutput("reset state", 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
    checkValue("reset out_data", {8'h00, out_data}, 16'h0000);

    vecs[0] = '{1'b1, 8'hB8, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 1'b1, 8'hF6, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h00, 1'b1, ksTab[2], 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'hB8, 1'b1, 8'hB8 ^ ksTab[3], 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, 1'b0);
      if (vecs[i].v) modelByte(vecs[i].d, eV, eS);
      checkOutput($sformatf("vec%0d", i), vecs[i].eV, vecs[i].eD, vecs[i].eS, vecs[i].eL, 16'h0000);
    end
    for (int p = 5; p < PKT_LEN; p++) begin
      sendByte($sformatf("zero pos%0d", p), 1'b1, 8'h00, ksTab[p-1], 1'b0);
    end
    txIdx = PKT_LEN - 1;

    // Second good sync declares lock together with its own output byte.
    applyStimulus(1'b1, 8'h47, 1'b0);
    txIdx++;
    modelByte(8'h47, eV, eS);
    checkOutput("second sync locks", 1'b1, 8'h47, 1'b1, 1'b1, 16'h0000);
    sendPayload("pkt2", 0, 1, PKT_LEN - 1, 1'b0);
    sendSync("pkt3 sync", 8'h47, 1'b0);
    sendPayload("pkt3", 1, 1, PKT_LEN - 1, 1'b0);

    // Same stream gap-free and then with random idle cycles.
    for (int run = 0; run < 2; run++) begin
      resetDut();
      for (int pk = 0; pk < 6; pk++) begin
        sendSync($sformatf("run%0d sync%0d", run, pk), (pk == 0 || pk == 4) ? 8'hB8 : 8'h47, 1'b0);
        sendPayload($sformatf("run%0d pkt%0d", run, pk), pk, 1, PKT_LEN - 1, run == 1);
      end
    end

    // Three corrupted syncs while locked, then reacquisition and counter clears.
    resetDut();
    sendSync("miss p0", 8'hB8, 1'b0);
    sendPayload("miss p0", 0, 1, PKT_LEN - 1, 1'b0);
    sendSync("miss p1", 8'h47, 1'b0);
    sendPayload("miss p1", 1, 1, PKT_LEN - 1, 1'b0);
    sendSync("miss p2", 8'h00, 1'b0);
    checkValue("locked after 1st miss", {15'h0, locked}, 16'h0001);
    sendPayload("miss p2", 2, 1, PKT_LEN - 1, 1'b1);
    sendSync("miss p3", 8'h00, 1'b0);
    sendPayload("miss p3", 3, 1, PKT_LEN - 1, 1'b0);
    sendSync("miss p4", 8'h00, 1'b0);
    checkValue("locked after 3rd miss", {15'h0, locked}, 16'h0000);
`ifdef DESCR_SYNC_ERR_CNT_EN
    checkValue("err after 3 misses", sync_err_cnt, 16'd3);
`else
    checkValue("err after 3 misses", sync_err_cnt, 16'd0);
`endif
    sendPayload("miss p4 hunt", 4, 1, PKT_LEN - 1, 1'b0);
    sendSync("miss p5", 8'hB8, 1'b0);
    sendPayload("miss p5", 5, 1, PKT_LEN - 1, 1'b0);
    sendSync("miss p6", 8'h47, 1'b0);
    sendPayload("miss p6", 0, 1, PKT_LEN - 1, 1'b0);
    sendSync("miss p7 clr", 8'h00, 1'b1);
    sendPayload("miss p7", 1, 1, PKT_LEN - 1, 1'b0);
    sendSync("miss p8", 8'h00, 1'b0);
    sendPayload("miss p8", 2, 1, 20, 1'b0);
    sendByte("idle clr", 1'b0, 8'h00, 8'h00, 1'b1);
    sendPayload("miss p8b", 2, 21, PKT_LEN - 1, 1'b0);
    sendSync("miss p9", 8'h47, 1'b0);
    sendPayload("miss p9", 3, 1, PKT_LEN - 1, 1'b0);
    sendSync("miss p10", 8'h00, 1'b0);
    sendPayload("miss p10", 4, 1, PKT_LEN - 1, 1'b0);
    sendSync("miss p11", 8'h47, 1'b0);
    sendPayload("miss p11", 5, 1, 99, 1'b0);

    // Asynchronous reset at pos 100, checked before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
    checkValue("async reset out_data", {8'h00, out_data}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    for (int p = 100; p < PKT_LEN + 21; p++) begin
      junk = (p == PKT_LEN) ? 8'h47 : 8'($urandom);
      if (junk == 8'hB8) junk = 8'h00;
      sendByte($sformatf("hunt junk%0d", p), 1'b1, junk, 8'h00, 1'b0);
    end
    sendSync("reacq sync", 8'hB8, 1'b0);
    sendPayload("reacq", 2, 1, PKT_LEN - 1, 1'b0);
    sendSync("reacq lock", 8'h47, 1'b0);
    checkValue("relocked", {15'h0, locked}, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
